// File: rtl/mult_issue_pkg.sv
// Shared types for the multiply/divide issue queue: core configuration and the issued-op record.
package mult_issue_pkg;

    localparam int unsigned DEF_XLEN          = 32;
    localparam int unsigned DEF_TRANS_ID_BITS = 3;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned TRANS_ID_BITS;
    } cfg_t;

    localparam cfg_t cva6_cfg_empty = '{XLEN: DEF_XLEN, TRANS_ID_BITS: DEF_TRANS_ID_BITS};

    typedef enum logic [3:0] {
        NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC, CVXIF, ACCEL
    } fu_t;

    typedef enum logic [4:0] {
        ADD, MUL, MULH, MULHU, MULHSU, MULW, CLMUL, CLMULH, CLMULR,
        DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
    } fu_op_e;

    typedef struct packed {
        fu_t                           fu;
        fu_op_e                        operation;
        logic [DEF_XLEN-1:0]           operand_a;
        logic [DEF_XLEN-1:0]           operand_b;
        logic [DEF_XLEN-1:0]           imm;
        logic [DEF_TRANS_ID_BITS-1:0]  trans_id;
    } fu_data_t;

endpackage

// File: rtl/mult_issue_queue.sv
// In-order issue FIFO feeding the mul/div unit; divides wait for a free serial divider.
// Optional MULT_ISSUE_BYPASS_EN: an op reaching an empty queue may dispatch in its issue cycle.
module mult_issue_queue
    import mult_issue_pkg::*;
#(
    parameter cfg_t        CVA6Cfg = cva6_cfg_empty,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             issue_valid_i,
    output logic                             issue_ready_o,
    input  fu_data_t                         fu_data_i,
    output fu_data_t                         fu_data_o,
    output logic                             mult_valid_o,
    input  logic                             mult_ready_i,
    input  logic                             res_valid_i,
    input  logic [CVA6Cfg.TRANS_ID_BITS-1:0] res_trans_id_i,
    output logic [$clog2(MAX_OUT+1)-1:0]     outstanding_o,
    output logic                             div_busy_o,
    output logic                             empty_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned TID_W = CVA6Cfg.TRANS_ID_BITS;
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

    // Handshakes: an op enters on issue_valid_i & issue_ready_o at a posedge; the unit
    // takes the op on fu_data_o whenever mult_valid_o is high (no back-pressure beyond mult_ready_i).

    fu_data_t          mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              div_busy_q, div_busy_d;
    logic [TID_W-1:0]  div_id_q, div_id_d;

    fu_data_t          head;
    logic              fifo_empty, fifo_full;
    logic              out_room, div_ok;
    logic              head_is_div, in_is_div;
    logic              head_fire, byp_fire, dispatch, push;
    logic              disp_is_div;
    logic [TID_W-1:0]  disp_id;
    logic              res_dec, div_ret;

    function automatic logic is_div_op(fu_op_e op);
        return op inside {DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW};
    endfunction

    always_comb begin
        head        = mem_q[rd_ptr_q[IDX_W-1:0]];
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        out_room    = (out_q < MAX_OUT_C);
        div_ok      = mult_ready_i && !div_busy_q;
        head_is_div = is_div_op(head.operation);
        in_is_div   = is_div_op(fu_data_i.operation);

        head_fire   = !fifo_empty && out_room && (!head_is_div || div_ok) && !flush_i;
`ifdef MULT_ISSUE_BYPASS_EN
        byp_fire    = fifo_empty && issue_valid_i && out_room && (!in_is_div || div_ok) && !flush_i;
`else
        byp_fire    = 1'b0;
`endif
        dispatch    = head_fire || byp_fire;
        disp_is_div = byp_fire ? in_is_div : head_is_div;
        disp_id     = byp_fire ? TID_W'(fu_data_i.trans_id) : TID_W'(head.trans_id);
        // A bypassed op never occupies a slot.
        push        = issue_valid_i && !fifo_full && !flush_i && !byp_fire;

        res_dec     = res_valid_i && (out_q != '0);
        div_ret     = res_valid_i && div_busy_q && (res_trans_id_i == div_id_q);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        out_d      = out_q;
        div_busy_d = div_busy_q;
        div_id_d   = div_id_q;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            out_d      = '0;
            div_busy_d = 1'b0;
        end else begin
            if (push)      wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (head_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);

            case ({dispatch, res_dec})
                2'b10:   out_d = out_q + OUT_W'(1);
                2'b01:   out_d = out_q - OUT_W'(1);
                default: out_d = out_q;
            endcase

            // A divide only dispatches with the divider idle, so set and clear never coincide.
            if (dispatch && disp_is_div) begin
                div_busy_d = 1'b1;
                div_id_d   = disp_id;
            end else if (div_ret) begin
                div_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_q      <= '0;
            div_busy_q <= 1'b0;
            div_id_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_q      <= out_d;
            div_busy_q <= div_busy_d;
            div_id_q   <= div_id_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= fu_data_i;
    end

    always_comb begin
        issue_ready_o = !fifo_full;
        mult_valid_o  = dispatch;
        fu_data_o     = byp_fire ? fu_data_i : (fifo_empty ? '0 : head);
        outstanding_o = out_q;
        div_busy_o    = div_busy_q;
        empty_o       = fifo_empty && (out_q == '0);
    end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Bench for mult_issue_queue: queue-based reference model compared every cycle, plus directed literals.
module tb_mult_issue_queue;
    import mult_issue_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;
    localparam int TIDW    = DEF_TRANS_ID_BITS;
    localparam int OUT_W   = $clog2(MAX_OUT + 1);

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             flush       = 1'b0;
    logic             issue_valid = 1'b0;
    logic             mult_ready  = 1'b0;
    logic             res_valid   = 1'b0;
    logic [TIDW-1:0]  res_id      = '0;
    fu_data_t         fu_in       = '0;
    fu_data_t         fu_out;
    logic             issue_ready, mult_valid, div_busy, empty;
    logic [OUT_W-1:0] outstanding;

    mult_issue_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .issue_valid_i  (issue_valid),
        .issue_ready_o  (issue_ready),
        .fu_data_i      (fu_in),
        .fu_data_o      (fu_out),
        .mult_valid_o   (mult_valid),
        .mult_ready_i   (mult_ready),
        .res_valid_i    (res_valid),
        .res_trans_id_i (res_id),
        .outstanding_o  (outstanding),
        .div_busy_o     (div_busy),
        .empty_o        (empty)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard counters and check tasks ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk_b(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_n(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_fu(string name, fu_data_t act, fu_data_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual op=%0d tid=%0d a=%0h expected op=%0d tid=%0d a=%0h at %0t",
                     name, act.operation, act.trans_id, act.operand_a,
                     exp.operation, exp.trans_id, exp.operand_a, $time);
        end
    endtask

    // ---------------- reference model: plain queue and counters ----------------
    fu_data_t        m_q[$];
    int              m_cnt  = 0;
    bit              m_busy = 1'b0;
    logic [TIDW-1:0] m_id   = '0;

    function automatic bit m_is_div(fu_op_e op);
        return (op == DIV) || (op == DIVU) || (op == DIVW) || (op == DIVUW) ||
               (op == REM) || (op == REMU) || (op == REMW) || (op == REMUW);
    endfunction

    function automatic bit m_can(fu_op_e op);
        if (m_cnt >= MAX_OUT) return 1'b0;
        if (m_is_div(op)) return mult_ready && !m_busy;
        return 1'b1;
    endfunction

    function automatic bit m_head_fire();
        if (m_q.size() == 0 || flush) return 1'b0;
        return m_can(m_q[0].operation);
    endfunction

    function automatic bit m_byp_fire();
`ifdef MULT_ISSUE_BYPASS_EN
        return (m_q.size() == 0) && issue_valid && !flush && m_can(fu_in.operation);
`else
        return 1'b0;
`endif
    endfunction

    function automatic fu_data_t m_exp_fu();
        if (m_byp_fire()) return fu_in;
        if (m_q.size() > 0) return m_q[0];
        return '0;
    endfunction

    task automatic model_step();
        bit       hf, bf, accept;
        fu_data_t d;
        d = '0;
        if (!rst_n || flush) begin
            m_q.delete();
            m_cnt  = 0;
            m_busy = 1'b0;
            return;
        end
        hf     = m_head_fire();
        bf     = m_byp_fire();
        accept = issue_valid && (m_q.size() < DEPTH) && !bf;
        if (hf) d = m_q.pop_front();
        else if (bf) d = fu_in;
        if (res_valid && m_busy && res_id == m_id) m_busy = 1'b0;
        if ((hf || bf) && m_is_div(d.operation)) begin
            m_busy = 1'b1;
            m_id   = d.trans_id;
        end
        if (res_valid && m_cnt > 0) m_cnt--;
        if (hf || bf) m_cnt++;
        if (accept) m_q.push_back(fu_in);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk_b("m_issue_ready", issue_ready, m_q.size() < DEPTH);
            chk_b("m_mult_valid", mult_valid, m_head_fire() || m_byp_fire());
            chk_fu("m_fu_data", fu_out, m_exp_fu());
            chk_n("m_outstanding", int'(outstanding), m_cnt);
            chk_b("m_div_busy", div_busy, m_busy);
            chk_b("m_empty", empty, (m_q.size() == 0) && (m_cnt == 0));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic fu_data_t mk(fu_op_e op, int id);
        fu_data_t d;
        d           = '0;
        d.fu        = MULT;
        d.operation = op;
        d.operand_a = DEF_XLEN'(id * 32'h1111);
        d.operand_b = DEF_XLEN'(32'hA5A5_0000 + id);
        d.imm       = DEF_XLEN'(id);
        d.trans_id  = TIDW'(id);
        return d;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic issue(fu_op_e op, int id);
        issue_valid = 1'b1;
        fu_in       = mk(op, id);
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        fu_in       = '0;
    endtask

    task automatic res(int id);
        res_valid = 1'b1;
        res_id    = TIDW'(id);
    endtask

    task automatic res_off();
        res_valid = 1'b0;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: run did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        cmp_en = 1'b1;
        nxt();
        chk_b("rst_issue_ready", issue_ready, 1'b1);
        chk_b("rst_mult_valid", mult_valid, 1'b0);
        chk_fu("rst_fu_data", fu_out, '0);
        chk_n("rst_outstanding", int'(outstanding), 0);
        chk_b("rst_div_busy", div_busy, 1'b0);
        chk_b("rst_empty", empty, 1'b1);
        nxt();
        rst_n = 1'b1;

`ifdef MULT_ISSUE_BYPASS_EN
        mult_ready = 1'b1;
        issue(MUL, 5);
        neg(); chk_b("byp_valid", mult_valid, 1'b1); chk_n("byp_tid", int'(fu_out.trans_id), 5); nxt();
        idle();
        neg(); chk_n("byp_out1", int'(outstanding), 1); chk_b("byp_not_empty", empty, 1'b0); nxt();
        res(5); nxt(); res_off();
        neg(); chk_b("byp_empty", empty, 1'b1); nxt();
        mult_ready = 1'b0;
        issue(DIV, 1);
        neg(); chk_b("byp_div_held", mult_valid, 1'b0); nxt();
        idle(); mult_ready = 1'b1;
        neg(); chk_b("byp_div_go", mult_valid, 1'b1); chk_n("byp_div_tid", int'(fu_out.trans_id), 1); nxt();
        res(1); nxt(); res_off();
        neg(); chk_b("byp_div_done", empty, 1'b1); nxt();
`else
        // Single MUL: one-cycle issue-to-dispatch, result two cycles after dispatch.
        mult_ready = 1'b1;
        issue(MUL, 3);
        neg(); chk_b("s1_no_disp_issue_cycle", mult_valid, 1'b0); nxt();
        idle();
        neg(); chk_b("s1_disp", mult_valid, 1'b1); chk_n("s1_tid", int'(fu_out.trans_id), 3);
               chk_n("s1_out0", int'(outstanding), 0); nxt();
        neg(); chk_n("s1_out1", int'(outstanding), 1); chk_b("s1_quiet", mult_valid, 1'b0); nxt();
        res(3);
        neg(); chk_n("s1_out_res_cycle", int'(outstanding), 1); nxt();
        res_off();
        neg(); chk_n("s1_out_back0", int'(outstanding), 0); chk_b("s1_empty", empty, 1'b1); nxt();

        // DIV then MUL back to back.
        issue(DIV, 1);
        neg(); chk_b("s2_wait", mult_valid, 1'b0); nxt();
        issue(MUL, 2);
        neg(); chk_b("s2_div_disp", mult_valid, 1'b1); chk_n("s2_div_tid", int'(fu_out.trans_id), 1);
               chk_b("s2_div_op", fu_out.operation == DIV, 1'b1); nxt();
        idle();
        neg(); chk_b("s2_busy", div_busy, 1'b1); chk_b("s2_mul_disp", mult_valid, 1'b1);
               chk_n("s2_mul_tid", int'(fu_out.trans_id), 2); chk_n("s2_out1", int'(outstanding), 1); nxt();
        res(1);
        neg(); chk_n("s2_out2", int'(outstanding), 2); nxt();
        res(2);
        neg(); chk_b("s2_busy_clr", div_busy, 1'b0); chk_n("s2_out_dec", int'(outstanding), 1); nxt();
        res_off();
        neg(); chk_b("s2_empty", empty, 1'b1); nxt();

        // Second DIV waits for the first one's result.
        issue(DIV, 1);
        neg(); nxt();
        issue(DIV, 4);
        neg(); chk_b("s3_first_disp", mult_valid, 1'b1); nxt();
        idle();
        neg(); chk_b("s3_held_a", mult_valid, 1'b0); chk_n("s3_head_tid", int'(fu_out.trans_id), 4); nxt();
        neg(); chk_b("s3_held_b", mult_valid, 1'b0); nxt();
        res(1);
        neg(); chk_b("s3_held_res_cycle", mult_valid, 1'b0); chk_b("s3_busy_res_cycle", div_busy, 1'b1); nxt();
        res_off();
        neg(); chk_b("s3_second_disp", mult_valid, 1'b1); chk_n("s3_second_tid", int'(fu_out.trans_id), 4);
               chk_n("s3_out0", int'(outstanding), 0); nxt();
        res(4);
        neg(); chk_b("s3_busy_again", div_busy, 1'b1); nxt();
        res_off();
        neg(); chk_b("s3_empty", empty, 1'b1); nxt();

        // Fill to full behind a blocked DIV head.
        mult_ready = 1'b0;
        issue(DIV, 0);
        neg(); chk_b("s4_nv0", mult_valid, 1'b0); nxt();
        issue(MUL, 1);
        neg(); chk_b("s4_nv1", mult_valid, 1'b0); nxt();
        issue(MUL, 2);
        neg(); chk_b("s4_nv2", mult_valid, 1'b0); nxt();
        issue(MUL, 3);
        neg(); chk_b("s4_ready_at3", issue_ready, 1'b1); nxt();
        issue(MUL, 5);
        neg(); chk_b("s4_full", issue_ready, 1'b0); chk_b("s4_nv_full", mult_valid, 1'b0);
               chk_n("s4_head_tid", int'(fu_out.trans_id), 0); nxt();
        neg(); chk_b("s4_still_full", issue_ready, 1'b0); nxt();
        idle(); flush = 1'b1;
        neg(); chk_b("s4_flush_nv", mult_valid, 1'b0); nxt();
        flush = 1'b0;
        neg(); chk_b("s4_flushed_empty", empty, 1'b1); chk_b("s4_flushed_ready", issue_ready, 1'b1);
               chk_fu("s4_flushed_fu", fu_out, '0); nxt();

        // Flush with three queued and two outstanding; late result ignored.
        mult_ready = 1'b1;
        issue(MUL, 6);
        neg(); nxt();
        issue(DIV, 7);
        neg(); chk_n("s5_tid6", int'(fu_out.trans_id), 6); nxt();
        issue(DIV, 0);
        neg(); chk_n("s5_tid7", int'(fu_out.trans_id), 7); chk_n("s5_out1", int'(outstanding), 1); nxt();
        issue(MUL, 2);
        neg(); chk_b("s5_div_blocked", mult_valid, 1'b0); chk_n("s5_out2", int'(outstanding), 2); nxt();
        issue(MUL, 5);
        neg(); chk_b("s5_still_blocked", mult_valid, 1'b0); nxt();
        idle(); flush = 1'b1;
        neg(); chk_b("s5_flush_nv", mult_valid, 1'b0); chk_b("s5_pre_busy", div_busy, 1'b1);
               chk_b("s5_pre_not_empty", empty, 1'b0); nxt();
        flush = 1'b0; res(7);
        neg(); chk_b("s5_post_empty", empty, 1'b1); chk_n("s5_post_out", int'(outstanding), 0);
               chk_b("s5_post_busy", div_busy, 1'b0); nxt();
        res_off();
        neg(); chk_n("s5_late_ignored", int'(outstanding), 0); chk_b("s5_late_empty", empty, 1'b1); nxt();

        // Outstanding limit: the fifth MUL waits until a result returns.
        for (int i = 0; i < 5; i++) begin
            issue(MUL, i);
            neg(); chk_b("s6_stream_valid", mult_valid, i > 0); nxt();
        end
        idle(); res(0);
        neg(); chk_n("s6_out_max", int'(outstanding), 4); chk_b("s6_limit_nv", mult_valid, 1'b0);
               chk_n("s6_head_tid", int'(fu_out.trans_id), 4); nxt();
        res_off();
        neg(); chk_n("s6_out3", int'(outstanding), 3); chk_b("s6_released", mult_valid, 1'b1); nxt();
        neg(); chk_n("s6_out4_again", int'(outstanding), 4); nxt();
        for (int i = 0; i < 4; i++) begin
            res(i + 1);
            nxt();
        end
        res_off();
        neg(); chk_n("s6_drained", int'(outstanding), 0); chk_b("s6_empty", empty, 1'b1); nxt();
`endif

        // Asynchronous reset in the middle of activity.
        mult_ready = 1'b0;
        issue(MUL, 3); nxt();
        issue(DIV, 1); nxt();
        issue(DIV, 2); nxt();
        idle();
        neg(); chk_n("r_pre_out", int'(outstanding), 1); chk_b("r_pre_not_empty", empty, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_n("r_async_out", int'(outstanding), 0);
        chk_b("r_async_empty", empty, 1'b1);
        chk_b("r_async_ready", issue_ready, 1'b1);
        chk_b("r_async_nv", mult_valid, 1'b0);
        chk_fu("r_async_fu", fu_out, '0);
        nxt();
        rst_n = 1'b1;
        neg(); chk_b("r_post_empty", empty, 1'b1); nxt();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
